// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file and the forwarding unit.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package rf_pkg;

  localparam int          RF_DATA_W     = 32;
  localparam int          RF_ADDR_W     = 5;
  localparam int          RF_SP_IDX     = 29;
  localparam logic [31:0] RF_SP_INIT    = 32'h0000_7FFC;

  // Widest register address any instance may use; narrower addresses are
  // zero-extended to this width before they reach rf_bypass_sel.
  localparam int          RF_ADDR_MAX_W = 8;

  typedef logic [RF_ADDR_MAX_W-1:0] rf_addr_t;

  // Returns {hit, port}: hit when an enabled write this cycle targets a
  // nonzero addr; port 1 outranks port 0 because it is the later stage.
  function automatic logic [1:0] rf_bypass_sel(
    input rf_addr_t                   addr,
    input logic [1:0]                 wr_en,
    input logic [2*RF_ADDR_MAX_W-1:0] wr_addr
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (addr != '0) begin
      if (wr_en[1] && (wr_addr[RF_ADDR_MAX_W +: RF_ADDR_MAX_W] == addr)) begin
        sel = 2'b11;
      end else if (wr_en[0] && (wr_addr[0 +: RF_ADDR_MAX_W] == addr)) begin
        sel = 2'b10;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write bits: set by decode, cleared by writeback writes.
// Latency: updates on the rising edge; pend/pend_any are registered outputs.
// Backpressure: none; every set/clear request is absorbed in the cycle it arrives.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             wr_en,
  input  logic [2*ADDR_W-1:0]    wr_addr,
  input  logic                   pend_set_en,
  input  logic [ADDR_W-1:0]      pend_set_addr,
  output logic [(2**ADDR_W)-1:0] pend,
  output logic                   pend_any
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] pend_nxt;

  // Clears first, then the set, so a new producer issued in the same cycle
  // keeps the register pending; r0 is forced clear.
  always_comb begin
    pend_nxt = pend;
    for (int p = 0; p < 2; p++) begin
      if (wr_en[p]) begin
        pend_nxt[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (pend_set_en) begin
      pend_nxt[pend_set_addr] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  // Pending-bit register; reset drops every outstanding hazard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  assign pend_any = |pend;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational reads, two write ports, pending scoreboard.
// Latency: reads are zero-latency with same-cycle write-through; writes land on the rising edge.
// Backpressure: none; all reads and writes complete every cycle.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int              DATA_W  = RF_DATA_W,
  parameter int              ADDR_W  = RF_ADDR_W,
  parameter int              NUM_RD  = 2,
  parameter int              SP_IDX  = RF_SP_IDX,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(RF_SP_INIT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic [1:0]               wr_en,
  input  logic [2*ADDR_W-1:0]      wr_addr,
  input  logic [2*DATA_W-1:0]      wr_data,
  input  logic                     pend_set_en,
  input  logic [ADDR_W-1:0]        pend_set_addr,
  output logic                     pend_any
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]          regs [DEPTH];
  logic [DEPTH-1:0]           pend;
  logic [1:0]                 wr_en_byp;
  logic [2*RF_ADDR_MAX_W-1:0] wr_addr_x;

  // Storage: r0 is never written so it stays zero; port 1 is applied last
  // so it wins a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] != '0)) begin
          regs[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // While reset is held the reads must show reset contents, not in-flight writes.
  assign wr_en_byp = rst ? 2'b00 : wr_en;
  assign wr_addr_x = {rf_addr_t'(wr_addr[ADDR_W +: ADDR_W]),
                      rf_addr_t'(wr_addr[0 +: ADDR_W])};

  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .pend_set_en   (pend_set_en),
    .pend_set_addr (pend_set_addr),
    .pend          (pend),
    .pend_any      (pend_any)
  );

  // One read port per k: bypass from the winning write, else stored value;
  // a register being written this cycle is reported as available.
  for (genvar k = 0; k < NUM_RD; k++) begin : gen_rd
    logic [ADDR_W-1:0] ra;
    logic [1:0]        sel;

    assign ra  = rd_addr[k*ADDR_W +: ADDR_W];
    assign sel = rf_bypass_sel(rf_addr_t'(ra), wr_en_byp, wr_addr_x);

    assign rd_data[k*DATA_W +: DATA_W] = sel[1] ? (sel[0] ? wr_data[DATA_W +: DATA_W]
                                                          : wr_data[0 +: DATA_W])
                                                : regs[ra];
    assign rd_pend[k] = pend[ra] & ~sel[1];
  end

endmodule
